// File: rtl/fft32_twiddle_sequencer.sv
// Control sequencer for one radix-2 MDC FFT stage: it counts pairs per frame,
// drives the twiddle ROM address/bypass, the commutator select and multiplier enable, and drains the stage at end of stream.
module fft32_twiddle_sequencer #(
    parameter int FRAME_LEN = 16,
    parameter int SHIFT     = 0,
    parameter int SW_BIT    = 3,
    parameter int PIPE_LAT  = 2,
    parameter int DRAIN_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in_valid,
    input  logic       in_last,
    output logic [2:0] tw_addr,
    output logic       tw_bypass,
    output logic       mult_en,
    output logic       sw_sel,
    output logic       out_valid,
    output logic       out_sof,
    output logic       busy,
    output logic       err_frame,
    output logic       err_ovf
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [3:0] CNT_MASK = 4'(FRAME_LEN - 1);
    localparam logic [3:0] HALF     = 4'(FRAME_LEN / 2);
    localparam logic [2:0] IDX_MASK = 3'(FRAME_LEN / 2 - 1);
    localparam logic [3:0] DLEN     = 4'(DRAIN_LEN);

    state_t state, state_nx;
    logic [3:0] cnt, dcnt;
    logic accept, advance, last_acc, abort;
    logic [2:0] idx, tw_addr_d;
    logic [PIPE_LAT:1] vld_pipe, sof_pipe;

    always_comb begin
        abort     = (state != IDLE) && !en;
        accept    = en && in_valid && (state == IDLE || state == RUN);
        advance   = accept || (state == DRAIN && en);
        last_acc  = accept && in_last;
        idx       = cnt[2:0] & IDX_MASK;
        tw_addr_d = idx << SHIFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = !in_last ? RUN : (DRAIN_LEN == 0) ? IDLE : DRAIN;
            RUN:   if (!en) state_nx = IDLE;
                   else if (last_acc) state_nx = (DRAIN_LEN == 0) ? IDLE : DRAIN;
            DRAIN: if (!en || dcnt == 4'd1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Any return to IDLE (drain done, abort, zero-length drain) restarts the frame count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dcnt <= '0;
        end else begin
            if (state_nx == IDLE)  cnt <= '0;
            else if (advance)      cnt <= (cnt + 4'd1) & CNT_MASK;
            if (state_nx != DRAIN)  dcnt <= '0;
            else if (state != DRAIN) dcnt <= DLEN;
            else                    dcnt <= dcnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tw_addr   <= '0;
            tw_bypass <= 1'b0;
            mult_en   <= 1'b0;
            sw_sel    <= 1'b0;
            err_frame <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            if (advance) begin
                tw_bypass <= (cnt < HALF);
                mult_en   <= (cnt >= HALF);
                tw_addr   <= (cnt < HALF) ? 3'd0 : tw_addr_d;
                sw_sel    <= cnt[SW_BIT];
            end
            err_frame <= last_acc && (cnt != CNT_MASK);
            err_ovf   <= (state == DRAIN) && in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            sof_pipe <= '0;
        end else if (abort) begin
            vld_pipe <= '0;
            sof_pipe <= '0;
        end else begin
            vld_pipe[1] <= advance;
            sof_pipe[1] <= advance && (cnt == 4'd0);
            for (int i = 2; i <= PIPE_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                sof_pipe[i] <= sof_pipe[i-1];
            end
        end
    end

    assign out_valid = vld_pipe[PIPE_LAT];
    assign out_sof   = sof_pipe[PIPE_LAT];
    assign busy      = (state != IDLE);
endmodule
